// File: rtl/neuron_acc.sv
`default_nettype none
// neuron_acc: accumulates signed product terms plus a once-per-sum bias and
// emits one saturated, optionally ReLU-clipped, result per N_TERMS terms.
module neuron_acc #(
  parameter int DIN_W   = 20,
  parameter int BIAS_W  = 8,
  parameter int N_TERMS = 784,
  parameter int OUT_W   = 22,
  parameter int RELU    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DIN_W-1:0]  din,
  input  logic [BIAS_W-1:0] bias,
  output logic              busy,
  output logic              out_valid,
  output logic [OUT_W-1:0]  dout,
  output logic              sat
);

  localparam int CNT_W    = ($clog2(N_TERMS) > 1) ? $clog2(N_TERMS) : 1;
  localparam int MAX_IN_W = (DIN_W > BIAS_W) ? DIN_W : BIAS_W;
  localparam int ACC_W    = MAX_IN_W + $clog2(N_TERMS + 1) + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        dout_q, dout_d;
  logic                    sat_q, sat_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic signed [ACC_W-1:0] din_ext, bias_ext, sum;
  logic [OUT_W-1:0]        result;
  logic                    clamp_hit;
  logic                    is_last;

  // The first term of a sum starts from the bias instead of the stale accumulator.
  always_comb begin
    din_ext   = {{(ACC_W - DIN_W){din[DIN_W-1]}}, din};
    bias_ext  = {{(ACC_W - BIAS_W){bias[BIAS_W-1]}}, bias};
    sum       = ((cnt_q == '0) ? bias_ext : acc_q) + din_ext;
    is_last   = (cnt_q == LAST_CNT);
    result    = sum[OUT_W-1:0];
    clamp_hit = 1'b0;
    if (sum > OUT_MAX) begin
      result    = OUT_MAX[OUT_W-1:0];
      clamp_hit = 1'b1;
    end else if (sum < OUT_MIN) begin
      result    = OUT_MIN[OUT_W-1:0];
      clamp_hit = 1'b1;
    end
    if ((RELU != 0) && result[OUT_W-1]) begin
      result = '0;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (in_valid) begin
      acc_d = sum;
      if (is_last) begin
        cnt_d       = '0;
        dout_d      = result;
        sat_d       = clamp_hit;
        out_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_acc.sv
`default_nettype none
// tb_neuron_acc: drives a plain and a ReLU instance with the same stream and
// compares every cycle against a reference model fed through a result queue.
module tb_neuron_acc;

  localparam int DIN_W   = 20;
  localparam int BIAS_W  = 8;
  localparam int N_TERMS = 4;
  localparam int OUT_W   = 22;
  localparam longint MAXV = (64'sd1 <<< (OUT_W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (OUT_W - 1));

  logic clk = 1'b0;
  logic rst, clr, in_valid;
  logic [DIN_W-1:0]  din;
  logic [BIAS_W-1:0] bias;

  logic busy_a, out_valid_a, sat_a;
  logic signed [OUT_W-1:0] dout_a;
  logic busy_b, out_valid_b, sat_b;
  logic signed [OUT_W-1:0] dout_b;

  always #5 clk = ~clk;

  neuron_acc #(.DIN_W(DIN_W), .BIAS_W(BIAS_W), .N_TERMS(N_TERMS), .OUT_W(OUT_W), .RELU(0)) u_plain (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din(din), .bias(bias),
    .busy(busy_a), .out_valid(out_valid_a), .dout(dout_a), .sat(sat_a)
  );

  neuron_acc #(.DIN_W(DIN_W), .BIAS_W(BIAS_W), .N_TERMS(N_TERMS), .OUT_W(OUT_W), .RELU(1)) u_relu (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din(din), .bias(bias),
    .busy(busy_b), .out_valid(out_valid_b), .dout(dout_b), .sat(sat_b)
  );

  typedef struct {
    longint da;
    bit     sa;
    longint db;
  } result_t;

  result_t exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;

  int      m_cnt  = 0;
  longint  m_acc  = 0;
  longint  m_da   = 0;
  bit      m_sa   = 0;
  longint  m_db   = 0;
  bit      exp_ov = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // One clock: check what the previous edge produced, then present new inputs.
  task automatic cyc(input bit r, input bit c, input bit v, input int d, input int b);
    result_t e;
    longint  s;
    @(negedge clk);
    if (exp_ov) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty got=0 expected=1");
      end else begin
        e    = exp_q.pop_front();
        m_da = e.da;
        m_sa = e.sa;
        m_db = e.db;
      end
    end
    check("ov_a",   out_valid_a, exp_ov);
    check("ov_b",   out_valid_b, exp_ov);
    check("dout_a", dout_a, m_da);
    check("dout_b", dout_b, m_db);
    check("sat_a",  sat_a, m_sa);
    check("sat_b",  sat_b, m_sa);
    check("busy_a", busy_a, m_cnt != 0);
    check("busy_b", busy_b, m_cnt != 0);

    rst      = r;
    clr      = c;
    in_valid = v;
    din      = DIN_W'(d);
    bias     = BIAS_W'(b);

    exp_ov = 0;
    if (!r) begin
      m_cnt = 0;
      m_acc = 0;
      m_da  = 0;
      m_sa  = 0;
      m_db  = 0;
      exp_q.delete();
    end else if (c) begin
      m_cnt = 0;
    end else if (v) begin
      s = ((m_cnt == 0) ? longint'(b) : m_acc) + longint'(d);
      m_acc = s;
      if (m_cnt == N_TERMS - 1) begin
        m_cnt = 0;
        if (s > MAXV) begin
          e.da = MAXV; e.sa = 1;
        end else if (s < MINV) begin
          e.da = MINV; e.sa = 1;
        end else begin
          e.da = s; e.sa = 0;
        end
        e.db = (e.da < 0) ? 0 : e.da;
        exp_q.push_back(e);
        exp_ov = 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic sum4(input int b, input int d0, input int d1, input int d2, input int d3);
    cyc(1, 0, 1, d0, b);
    cyc(1, 0, 1, d1, b);
    cyc(1, 0, 1, d2, b);
    cyc(1, 0, 1, d3, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0; bias = '0;
    repeat (2) @(posedge clk);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 5, 5);
    idle(1);

    // Basic sum with negative bias
    sum4(-3, 1, 2, 3, 4);
    idle(2);
    check("t1_dout_a", dout_a, 7);
    check("t1_dout_b", dout_b, 7);

    // Positive then negative saturation, back-to-back
    sum4(127, 524287, 524287, 524287, 524287);
    sum4(-128, -524288, -524288, -524288, -524288);
    idle(1);
    check("t2_dout_a", dout_a, -2097152);
    check("t2_sat_a",  sat_a, 1);
    check("t2_dout_b", dout_b, 0);

    // ReLU clipping of an unsaturated negative result
    sum4(-128, 0, 0, 0, 0);
    sum4(5, 1, 1, 1, 1);
    idle(1);
    check("t3_dout_b", dout_b, 9);

    // Gaps mid-sum, bias changing after the first term, then back-to-back sum
    cyc(1, 0, 1, 10, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 99);
      cyc(1, 0, 0, 0, 99);
      cyc(1, 0, 0, 0, 99);
      cyc(1, 0, 1, 20 + 10 * k, 99);
    end
    sum4(1, 1, 1, 1, 1);
    idle(1);
    check("t4_dout_a", dout_a, 5);

    // clr with the third term, then with the last term
    cyc(1, 0, 1, 5, 0);
    cyc(1, 0, 1, 5, 0);
    cyc(1, 1, 1, 5, 0);
    sum4(0, 2, 2, 2, 2);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    idle(1);
    check("t5_dout_a", dout_a, 8);
    sum4(0, 2, 2, 2, 2);
    idle(1);

    // Mid-sum reset, then a full sum
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(0, 1, 1, 7, 0);
    idle(1);
    check("t6_rst_dout", dout_a, 0);
    sum4(0, 1, 1, 1, 1);
    idle(2);
    check("t6_dout_a", dout_a, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
